// File: rtl/bit_4_serial_subtractor.sv
// ============================================================================
// Module   : bit_4_serial_subtractor
// Brief    : LSB-first bit-serial subtractor (diff = a - b - bin) with a
//            start/done handshake. Define SUB_OVERFLOW_EN to add the ovf_o port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_4_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic               brw_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               busy_q;
    logic               done_q;

    // One full-subtractor cell evaluated on the current LSBs.
    logic               bit_d;
    logic               brw_d;
    logic [WIDTH-1:0]   res_d;

    assign bit_d = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    assign brw_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
        end else if (state_q == S_DONE) begin
            ovf_q   <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end
    end

    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        brw_q   <= bin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    brw_q  <= brw_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results are published only here, so they stay stable
                    // through the RUN phase of the next operation.
                    diff_q  <= res_q;
                    bout_q  <= brw_q;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: doc/bit_4_serial_subtractor.md
Name: bit_4_serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, LSB first, one full-subtractor cell per cycle.
- Counterpart of the parallel ripple adder. It trades that block's combinational carry chain for a registered borrow, giving minimal area.
- Used in multi-cycle datapaths next to the adder, with a start/done handshake to the controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- diff  output  WIDTH  result; registered, held between operations
- bout  output  1  borrow-out (1 = unsigned a < b + bin); registered, held
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse when diff/bout are updated

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit-cycles.
  - DONE -> IDLE unconditionally.
- Reset: on rst=1 at a clock edge:
  - state goes to IDLE;
  - diff, bout, busy and done go to 0;
  - internal shift registers, borrow register and bit counter go to 0.
- Reset has priority over every other event, including mid-RUN; the partial result is discarded.
- Accept: start=1 in IDLE loads a and b into shift registers, bin into the borrow register and 0 into the counter. busy rises the next cycle.
- RUN, each cycle, with x = a_sh[0], y = b_sh[0], r = borrow register:
  - d = x ^ y ^ r
  - next r = (~x & y) | (~(x ^ y) & r)
  - d is shifted into the MSB of the result shift register; a_sh and b_sh shift right; the counter increments.
  - When the counter reaches WIDTH-1, that cycle is the last bit and the next state is DONE.
- DONE:
  - diff <= result shift register and bout <= final borrow, both committed at entry to DONE.
  - done = 1 for exactly that one cycle; busy = 0.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start during RUN or DONE is ignored, with no queueing. a, b and bin may change freely after acceptance.
- start held high continuously is re-accepted on the first IDLE cycle after DONE.
- diff and bout change only at entry to DONE or on reset. They are stable otherwise, including during RUN of the next operation.
- Arithmetic: modulo 2^WIDTH. Borrow wraps naturally:
  - a=0, b=0, bin=1 gives all-ones with bout=1.
  - a = b with bin=0 gives 0 with bout=0.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - An extra output port ovf (output, 1 bit) is present.
  - ovf is the two's-complement overflow of a - b - bin: set when a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - It is computed from the captured operand MSBs and committed with diff at entry to DONE.
  - Reset value 0; held like diff.
- Undefined: the ovf port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles, then idle -> diff=0, bout=0, busy=0, done=0 (ovf=0 if enabled).
- a=9, b=3, bin=0, start pulse -> busy high for 4 cycles, then done pulses with diff=6, bout=0.
- a=3, b=9, bin=0 -> diff=4'hA, bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
- During RUN, pulse start with a=1, b=1 -> ignored; the original result is delivered after exactly WIDTH+1 cycles and no second done occurs.
- Assert rst in the 2nd RUN cycle of a=9, b=3 -> next cycle IDLE with all outputs 0 and no done. A fresh a=5, b=2 then gives diff=3.
- SUB_OVERFLOW_EN defined:
  - a=7, b=4'hF, bin=0 -> diff=8, bout=1, ovf=1.
  - a=5, b=2 -> ovf=0.
